// File: rtl/furv_pkg.sv
// rtl/furv_pkg.sv - shared types and constants for the furv Wishbone bridge
package furv_pkg;

  localparam int ADR_W = 30;
  localparam int DAT_W = 32;
  localparam int SEL_W = 4;

  localparam logic [DAT_W-1:0] ERR_DATA_DEFAULT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } bus_state_t;

  // Counter width able to hold TIMEOUT, never narrower than one bit.
  function automatic int timer_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/furv_bus_timer.sv
// rtl/furv_bus_timer.sv - saturating wait-cycle counter with timeout flag
module furv_bus_timer
  import furv_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = timer_width(TIMEOUT);
  localparam logic [W-1:0] LIMIT = W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  // Expired during the last permitted REQ cycle, so the abort lands at its end.
  assign expired = (TIMEOUT != 0) && (count == LIMIT);

endmodule

// File: rtl/furv_wb_bridge.sv
// rtl/furv_wb_bridge.sv - furv data port to Wishbone classic single-cycle bridge
module furv_wb_bridge
  import furv_pkg::*;
#(
  parameter int               TIMEOUT  = 255,
  parameter logic [DAT_W-1:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem,
  input  logic             mem_write,
  input  logic [ADR_W-1:0] addr,
  input  logic [SEL_W-1:0] sel,
  input  logic [DAT_W-1:0] data_out,
  output logic [DAT_W-1:0] data_in,
  output logic             ack,
  output logic [ADR_W-1:0] wb_adr_o,
  output logic [DAT_W-1:0] wb_dat_o,
  output logic [SEL_W-1:0] wb_sel_o,
  output logic             wb_we_o,
  output logic             wb_cyc_o,
  output logic             wb_stb_o,
  input  logic [DAT_W-1:0] wb_dat_i,
  input  logic             wb_ack_i,
  input  logic             wb_err_i,
  input  logic             err_clr,
  output logic             bus_error,
  output logic [ADR_W-1:0] err_addr
);

  bus_state_t       state, state_n;
  logic [DAT_W-1:0] data_in_n, wb_dat_n;
  logic [ADR_W-1:0] wb_adr_n, err_addr_n;
  logic [SEL_W-1:0] wb_sel_n;
  logic             ack_n, wb_we_n, wb_cyc_n, wb_stb_n, bus_error_n;
  logic             timer_expired;

  furv_bus_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (state != REQ),
    .enable (state == REQ),
    .expired(timer_expired)
  );

  always_comb begin
    state_n     = state;
    data_in_n   = data_in;
    wb_adr_n    = wb_adr_o;
    wb_dat_n    = wb_dat_o;
    wb_sel_n    = wb_sel_o;
    wb_we_n     = wb_we_o;
    wb_cyc_n    = wb_cyc_o;
    wb_stb_n    = wb_stb_o;
    err_addr_n  = err_addr;
    ack_n       = 1'b0;
    // A new failure below overrides a coincident clear.
    bus_error_n = bus_error & ~err_clr;

    case (state)
      IDLE: begin
        if (mem) begin
          wb_adr_n = addr;
          wb_dat_n = data_out;
          wb_sel_n = sel;
          wb_we_n  = mem_write;
          wb_cyc_n = 1'b1;
          wb_stb_n = 1'b1;
          state_n  = REQ;
        end
      end
      REQ: begin
        if (wb_err_i || (!wb_ack_i && timer_expired)) begin
          wb_cyc_n    = 1'b0;
          wb_stb_n    = 1'b0;
          data_in_n   = ERR_DATA;
          bus_error_n = 1'b1;
          err_addr_n  = wb_adr_o;
          ack_n       = 1'b1;
          state_n     = RESP;
        end else if (wb_ack_i) begin
          wb_cyc_n = 1'b0;
          wb_stb_n = 1'b0;
          if (!wb_we_o) begin
            data_in_n = wb_dat_i;
          end
          ack_n   = 1'b1;
          state_n = RESP;
        end
      end
      // mem is still held by the finishing instruction here and is ignored.
      RESP: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      data_in   <= '0;
      wb_adr_o  <= '0;
      wb_dat_o  <= '0;
      wb_sel_o  <= '0;
      wb_we_o   <= 1'b0;
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
      ack       <= 1'b0;
      bus_error <= 1'b0;
      err_addr  <= '0;
    end else begin
      state     <= state_n;
      data_in   <= data_in_n;
      wb_adr_o  <= wb_adr_n;
      wb_dat_o  <= wb_dat_n;
      wb_sel_o  <= wb_sel_n;
      wb_we_o   <= wb_we_n;
      wb_cyc_o  <= wb_cyc_n;
      wb_stb_o  <= wb_stb_n;
      ack       <= ack_n;
      bus_error <= bus_error_n;
      err_addr  <= err_addr_n;
    end
  end

endmodule

// File: doc/furv_wb_bridge.md
Name: furv_wb_bridge

Overview:
Downstream neighbour of the furv core's data port. Converts the core's level-held request (mem, mem_write, addr, sel, data_out) into single Wishbone classic cycles, then returns a one-cycle ack with registered read data. The core advances only on that ack. A programmable timeout keeps the core from stalling forever on a dead slave, and it records a sticky error.

Parameters:
TIMEOUT, 255, maximum cycles in REQ without wb_ack_i/wb_err_i before abort; 0 disables the timeout
ERR_DATA, 32'hFFFF_FFFF, read data returned to the core on error or timeout

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
mem  in  1  core request valid; held until ack
mem_write  in  1  1 = store, 0 = load
addr  in  30  core word address
sel  in  4  core byte lanes
data_out  in  32  core store data, already lane-replicated by the core
data_in  out  32  read data to the core
ack  out  1  one-cycle completion pulse to the core
wb_adr_o  out  30  Wishbone word address
wb_dat_o  out  32  Wishbone write data
wb_sel_o  out  4  Wishbone byte select
wb_we_o  out  1  Wishbone write enable
wb_cyc_o  out  1  Wishbone cycle
wb_stb_o  out  1  Wishbone strobe
wb_dat_i  in  32  Wishbone read data
wb_ack_i  in  1  Wishbone normal termination
wb_err_i  in  1  Wishbone error termination
err_clr  in  1  clears bus_error
bus_error  out  1  sticky: an error or timeout has occurred since reset or clear
err_addr  out  30  word address of the most recent failed access

Behaviour:
- Reset: state IDLE; data_in, wb_adr_o, wb_dat_o, err_addr = 0; wb_sel_o = 0; ack, wb_we_o, wb_cyc_o, wb_stb_o, bus_error = 0; timer = 0. All outputs are registered.
- IDLE: if mem=1, capture addr, data_out, sel and mem_write into the wb_* registers, set cyc and stb, clear the timer, and go to REQ. Otherwise stay.
- REQ: cyc, stb and the address/data/sel/we fields stay stable. Priority on each cycle:
  - wb_err_i=1: drop cyc/stb, set data_in=ERR_DATA, set bus_error, capture err_addr=wb_adr_o, go to RESP.
  - else wb_ack_i=1: drop cyc/stb, set data_in=wb_dat_i (write: data_in unchanged), go to RESP.
  - else TIMEOUT!=0 and timer==TIMEOUT-1: abort exactly as for wb_err_i.
  - else increment the timer.
- RESP: ack=1 for exactly this cycle, then go to IDLE. mem is still high from the old instruction in this cycle and must be ignored.
- Latency with a zero-wait slave that acks in the first REQ cycle: mem seen in cycle 0, cyc/stb in cycle 1, ack in cycle 2, core commits at the end of cycle 2. Each access takes 3 cycles. Back-to-back requests re-enter REQ one cycle after RESP.
- Timeout boundary: with TIMEOUT=N, a wb_ack_i in REQ cycle N (1-based) still wins. With no termination, the abort takes effect at the end of REQ cycle N.
- Timer width is $clog2(TIMEOUT+1), with a minimum of 1. The timer saturates and never wraps.
- bus_error: set and err_clr in the same cycle → set wins.
- mem dropping during REQ is illegal for the core. The bridge ignores it and completes the cycle.
- rst asserted mid-REQ: cyc/stb are low on the next edge and no ack is issued. A slave ack arriving after reset is ignored in IDLE.
- wb_ack_i or wb_err_i while in IDLE or RESP is ignored.

Decomposition:
- Shared package furv_pkg holds:
  - the state enum {IDLE, REQ, RESP}
  - the default ERR_DATA constant
  - the Wishbone width constants (ADR_W=30, DAT_W=32, SEL_W=4)
- One sub-module, furv_bus_timer. Inputs: clk, rst, clear, enable. Parameter TIMEOUT. Output: expired. It holds the saturating counter so the timeout can be verified in isolation.

Test Plan:
- Load, zero-wait slave returning 32'h1234_5678 at addr 30'h100 → wb_cyc_o high in cycle 1 with wb_adr_o=30'h100, wb_we_o=0; ack in cycle 2 with data_in=32'h1234_5678; one cyc only.
- Store, sel=4'b0100, data_out=32'hAB_AB_AB_AB, slave acks after 3 waits → wb_we_o=1, wb_sel_o=4'b0100, stable for 4 cycles; ack one cycle after wb_ack_i; bus_error stays 0.
- TIMEOUT=4, slave silent, addr 30'h3FF → cyc/stb drop after 4 REQ cycles; ack with data_in=32'hFFFF_FFFF; bus_error=1, err_addr=30'h3FF.
- TIMEOUT=4, wb_ack_i in REQ cycle 4 → normal completion with slave data; bus_error stays 0.
- wb_err_i and wb_ack_i together → error path wins. Then err_clr pulse → bus_error=0. err_clr coincident with a new error → bus_error stays 1.
- rst pulsed in REQ cycle 2 → cyc/stb=0 next cycle, no ack, later wb_ack_i ignored. Two back-to-back loads → exactly two cyc pulses and two ack pulses, with no re-issue during RESP.
